// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge: captures a full neuron-layer output vector once every
// neuron is valid and streams it one word per clock into the next layer's serial port.

module layer_serializer_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] word_q;

  // Frame storage needs no reset: it is only read after an accepted capture.
  always_ff @(posedge clk) begin
    if (load) word_q <= din;
  end

  assign dout = sel ? word_q : '0;
endmodule

module layer_serializer #(
  parameter int NEURON_NUM = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NEURON_NUM*DATA_WIDTH-1:0] layer_output,
  input  logic [NEURON_NUM-1:0]            layer_output_valid,
  output logic [DATA_WIDTH-1:0]            next_input,
  output logic                             next_input_valid,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overrun
);
  localparam int IDX_W = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NEURON_NUM - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                               state;
  logic [IDX_W-1:0]                     idx, idx_nxt;
  logic                                 all_valid, all_valid_d, start, accept, at_last;
  logic [NEURON_NUM-1:0]                lane_sel;
  logic [NEURON_NUM-1:0][DATA_WIDTH-1:0] lane_word;
  logic [DATA_WIDTH-1:0]                word_nxt;

  assign all_valid = &layer_output_valid;
  assign start     = all_valid & ~all_valid_d;
  assign at_last   = (idx == LAST);
  assign idx_nxt   = idx + 1'b1;
  // A start is taken when idle or on the last word; otherwise it is an overrun.
  assign accept    = start & ((state == IDLE) | at_last) & rst_n;

  for (genvar i = 0; i < NEURON_NUM; i++) begin : g_lane
    assign lane_sel[i] = (idx_nxt == IDX_W'(i));
    layer_serializer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk  (clk),
      .load (accept),
      .sel  (lane_sel[i]),
      .din  (layer_output[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout (lane_word[i])
    );
  end

  always_comb begin
    word_nxt = '0;
    for (int i = 0; i < NEURON_NUM; i++) word_nxt = word_nxt | lane_word[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      all_valid_d      <= 1'b0;
      next_input       <= '0;
      next_input_valid <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      all_valid_d <= all_valid;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      if (accept) begin
        // Word 0 comes straight from the input so it appears the cycle after start.
        state            <= SEND;
        idx              <= '0;
        next_input       <= layer_output[DATA_WIDTH-1:0];
        next_input_valid <= 1'b1;
        busy             <= 1'b1;
        frame_done       <= (LAST == '0);
      end else if (state == SEND) begin
        if (at_last) begin
          state            <= IDLE;
          idx              <= '0;
          next_input       <= '0;
          next_input_valid <= 1'b0;
          busy             <= 1'b0;
        end else begin
          idx        <= idx_nxt;
          next_input <= word_nxt;
          frame_done <= (idx_nxt == LAST);
          overrun    <= start;
        end
      end
    end
  end
endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: directed scenarios plus random traffic, each cycle
// compared against a frame-level reference model.

module tb_layer_serializer;
  localparam int N = 10;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   layer_output;
  logic [N-1:0]     layer_output_valid;
  logic [W-1:0]     next_input;
  logic             next_input_valid, busy, frame_done, overrun;

  int total = 0;
  int bad   = 0;

  // reference model: index of the word on the output (-1 = idle) and captured frame
  int           m_pos = -1;
  logic [W-1:0] m_frm [N];
  logic         m_avd = 1'b0;
  logic         m_ov  = 1'b0;

  layer_serializer #(.NEURON_NUM(N), .DATA_WIDTH(W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .layer_output       (layer_output),
    .layer_output_valid (layer_output_valid),
    .next_input         (next_input),
    .next_input_valid   (next_input_valid),
    .busy               (busy),
    .frame_done         (frame_done),
    .overrun            (overrun)
  );

  always #5 clk = ~clk;

  task automatic set_data(input int base);
    for (int i = 0; i < N; i++) layer_output[i*W +: W] = W'(base + i);
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    logic av, st;
    @(posedge clk);
    if (!rst_n) begin
      m_pos = -1; m_avd = 1'b0; m_ov = 1'b0;
    end else begin
      av = &layer_output_valid;
      st = av && !m_avd;
      m_avd = av;
      m_ov = 1'b0;
      if (m_pos < 0 || m_pos == N-1) begin
        if (st) begin
          for (int i = 0; i < N; i++) m_frm[i] = layer_output[i*W +: W];
          m_pos = 0;
        end else m_pos = -1;
      end else begin
        m_pos++;
        m_ov = st;
      end
    end
    #1;
  endtask

  function automatic logic [W+3:0] exp_out();
    logic [W-1:0] w;
    logic v;
    v = (m_pos >= 0);
    w = v ? m_frm[m_pos] : '0;
    return {w, v, v, (m_pos == N-1), m_ov};
  endfunction

  function automatic logic [W+3:0] act_out();
    return {next_input, next_input_valid, busy, frame_done, overrun};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; layer_output_valid = '1; set_data(16'h55);
    tick(); tick();
    total++;
    if (act_out() !== '0) begin
      bad++; $display("FAIL reset_state got=%h want=0", act_out());
    end
    layer_output_valid = '0; tick();
    rst_n = 1'b1; tick();
    total++;
    if (act_out() !== exp_out() || next_input_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release got=%h want=%h", act_out(), exp_out());
    end
  endtask

  task automatic test_basic();
    int nv = 0, nfd = 0, wrong = 0;
    set_data(0); layer_output_valid = '1;
    for (int t = 0; t < 14; t++) begin
      tick();
      layer_output_valid = '0;
      total++;
      if (act_out() !== exp_out()) begin
        bad++; $display("FAIL basic_model t=%0d got=%h want=%h", t, act_out(), exp_out());
      end
      if (next_input_valid) begin
        if (next_input !== W'(nv)) wrong++;
        if (frame_done && next_input !== W'(9)) wrong++;
        nv++;
      end else if (next_input !== '0 || busy !== 1'b0) wrong++;
      if (frame_done) nfd++;
    end
    total++;
    if (nv != N || nfd != 1 || wrong != 0) begin
      bad++; $display("FAIL basic_frame valid=%0d done=%0d wrong=%0d want=10/1/0", nv, nfd, wrong);
    end
  endtask

  task automatic test_held();
    int nfd = 0, nov = 0;
    set_data(16'h40); layer_output_valid = '1;
    for (int t = 0; t < 30; t++) begin
      if (t == 25) layer_output_valid = '0;
      tick();
      total++;
      if (act_out() !== exp_out()) begin
        bad++; $display("FAIL held_model t=%0d got=%h want=%h", t, act_out(), exp_out());
      end
      nfd += int'(frame_done);
      nov += int'(overrun);
    end
    total++;
    if (nfd != 1 || nov != 0) begin
      bad++; $display("FAIL held_level frames=%0d overruns=%0d want=1/0", nfd, nov);
    end
  endtask

  task automatic test_partial();
    int act = 0;
    set_data(16'h77);
    for (int t = 0; t < 12; t++) begin
      layer_output_valid = (t % 2 == 0) ? 10'h3FE : 10'h3FD;
      tick();
      act += int'(next_input_valid | busy | frame_done | overrun);
    end
    layer_output_valid = '0;
    total++;
    if (act != 0) begin
      bad++; $display("FAIL partial_valid active_cycles=%0d want=0", act);
    end
  endtask

  task automatic test_overrun();
    int nv = 0, nov = 0, wrong = 0;
    for (int t = 0; t < 16; t++) begin
      layer_output_valid = (t == 0 || t == 4) ? '1 : '0;
      set_data(t < 4 ? 16'h0300 : 16'hA000);
      tick();
      total++;
      if (act_out() !== exp_out()) begin
        bad++; $display("FAIL overrun_model t=%0d got=%h want=%h", t, act_out(), exp_out());
      end
      if (next_input_valid) begin
        if (next_input !== W'(16'h0300 + nv)) wrong++;
        nv++;
      end
      if (overrun) begin
        nov++;
        if (t != 4) wrong++;
      end
    end
    layer_output_valid = '0;
    total++;
    if (nv != N || nov != 1 || wrong != 0) begin
      bad++; $display("FAIL overrun_drop words=%0d overruns=%0d wrong=%0d want=10/1/0", nv, nov, wrong);
    end
  endtask

  task automatic test_back_to_back();
    int fd_t [$];
    int gaps = 0;
    logic [W-1:0] w10 = '0;
    for (int t = 0; t < 24; t++) begin
      layer_output_valid = (t == 0 || t == 10) ? '1 : '0;
      set_data(t < 10 ? 0 : 16'h0100);
      tick();
      total++;
      if (act_out() !== exp_out()) begin
        bad++; $display("FAIL b2b_model t=%0d got=%h want=%h", t, act_out(), exp_out());
      end
      if (t < 20 && !next_input_valid) gaps++;
      if (t == 10) w10 = next_input;
      if (frame_done) fd_t.push_back(t);
    end
    layer_output_valid = '0;
    total++;
    if (gaps != 0 || w10 !== 16'h0100 || fd_t.size() != 2 ||
        (fd_t.size() == 2 && fd_t[1] - fd_t[0] != 10)) begin
      bad++; $display("FAIL back_to_back gaps=%0d word=%h dones=%0d want=0/0100/2 spaced 10",
                      gaps, w10, fd_t.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 22; t++) begin
      layer_output_valid = (t == 0 || t == 6 || t == 7) ? '1 : '0;
      set_data(t < 6 ? 16'h0500 : 16'h0200);
      rst_n = (t != 6);
      tick();
      total++;
      if (act_out() !== exp_out()) begin
        bad++; $display("FAIL rstmid_model t=%0d got=%h want=%h", t, act_out(), exp_out());
      end
      if (t == 6) begin
        total++;
        if (act_out() !== '0) begin
          bad++; $display("FAIL rstmid_clear got=%h want=0", act_out());
        end
      end
      if (t == 7) begin
        total++;
        if (next_input !== 16'h0200 || next_input_valid !== 1'b1) begin
          bad++; $display("FAIL rstmid_restart got=%h/%b want=0200/1", next_input, next_input_valid);
        end
      end
    end
    layer_output_valid = '0; rst_n = 1'b1;
  endtask

  task automatic test_random();
    int r;
    for (int t = 0; t < 600; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      layer_output_valid = '1;
      else if (r < 7) layer_output_valid = '0;
      else            layer_output_valid = N'($urandom);
      for (int i = 0; i < N; i++) layer_output[i*W +: W] = W'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
      tick();
      total++;
      if (act_out() !== exp_out()) begin
        bad++; $display("FAIL random_model t=%0d got=%h want=%h", t, act_out(), exp_out());
      end
    end
    rst_n = 1'b1; layer_output_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; layer_output = '0; layer_output_valid = '0;
    test_reset();
    test_basic();
    test_held();
    test_partial();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
